// File: rtl/video_pkg.sv
// Shared video-path types: CRAM geometry, the CRAM write beat and the write-arbiter grant state.
package video_pkg;
  localparam int CRAM_AW = 8;
  localparam int CRAM_DW = 15;

  typedef struct packed {
    logic [CRAM_AW-1:0] addr;
    logic [CRAM_DW-1:0] data;
  } cram_wr_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_DMA, ARB_CPU} arb_state_t;
endpackage

// File: rtl/cram_wr_arb_if.sv
// Bundle of the CPU strobe, DMA handshake and CRAM write port around cram_wr_arb.
interface cram_wr_arb_if #(parameter int FIFO_DEPTH = 4);
  import video_pkg::*;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               cpu_we;
  logic [CRAM_AW-1:0] cpu_addr;
  logic [CRAM_DW-1:0] cpu_data;
  logic               dma_req;
  logic [CRAM_AW-1:0] dma_addr;
  logic [CRAM_DW-1:0] dma_data;
  logic               dma_ack;
  logic               blank;
  logic               ovf_clr;
  logic               cram_we;
  logic [CRAM_AW-1:0] cram_addr;
  logic [CRAM_DW-1:0] cram_data;
  logic               cpu_ovf;
  logic [CNT_W-1:0]   fifo_cnt;
  arb_state_t         state;

  modport master (
    output cpu_we, cpu_addr, cpu_data, dma_req, dma_addr, dma_data, blank, ovf_clr,
    input  dma_ack, cram_we, cram_addr, cram_data, cpu_ovf, fifo_cnt, state
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_data, dma_req, dma_addr, dma_data, blank, ovf_clr,
    output dma_ack, cram_we, cram_addr, cram_data, cpu_ovf, fifo_cnt, state
  );
endinterface

// File: rtl/cram_wr_fifo.sv
// Synchronous FIFO of CRAM write beats; a push into a full FIFO is accepted when a pop frees the slot.
module cram_wr_fifo
  import video_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cram_wr_t                 wdata,
  input  logic                     pop,
  output cram_wr_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cram_wr_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/cram_wr_arb.sv
// Palette CRAM write-port arbiter: buffered Z80 writes vs. bounded DMA bursts, one registered write per clk.
// Define CRAM_BLANK_WR_EN to restrict grants to blanking periods.
module cram_wr_arb
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DMA_BURST  = 8
) (
  input  logic            clk,
  input  logic            rst,
  cram_wr_arb_if.slave    bus
);
  cram_wr_t   cpu_wr;
  cram_wr_t   fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       gate;
  logic       burst_hit;
  logic       grant_dma;
  logic       grant_cpu;
  logic       ovf_set;
  logic [7:0] burst_cnt;

`ifdef CRAM_BLANK_WR_EN
  assign gate = bus.blank;
`else
  assign gate = 1'b1;
`endif

  assign cpu_wr    = {bus.cpu_addr, bus.cpu_data};
  assign burst_hit = !fifo_empty && (burst_cnt == 8'(DMA_BURST));
  // Reset suppresses every grant so nothing leaks out during the reset cycle.
  assign grant_dma = gate && !rst && bus.dma_req && !burst_hit;
  assign grant_cpu = gate && !rst && !fifo_empty && !grant_dma;
  assign ovf_set   = bus.cpu_we && fifo_full && !grant_cpu;
  assign bus.dma_ack = grant_dma;

  cram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cpu_we && !rst),
    .wdata (cpu_wr),
    .pop   (grant_cpu),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.state     <= ARB_IDLE;
      burst_cnt     <= '0;
      bus.cram_we   <= 1'b0;
      bus.cram_addr <= '0;
      bus.cram_data <= '0;
      bus.cpu_ovf   <= 1'b0;
    end else begin
      bus.cram_we <= grant_dma || grant_cpu;
      if (grant_dma) begin
        bus.cram_addr <= bus.dma_addr;
        bus.cram_data <= bus.dma_data;
      end else if (grant_cpu) begin
        bus.cram_addr <= fifo_head.addr;
        bus.cram_data <= fifo_head.data;
      end

      if (grant_dma)      bus.state <= ARB_DMA;
      else if (grant_cpu) bus.state <= ARB_CPU;
      else                bus.state <= ARB_IDLE;

      // Only DMA beats taken while CPU writes wait count toward the burst limit.
      if (grant_cpu || fifo_empty) burst_cnt <= '0;
      else if (grant_dma)          burst_cnt <= burst_cnt + 8'd1;

      if (ovf_set)          bus.cpu_ovf <= 1'b1;
      else if (bus.ovf_clr) bus.cpu_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cram_wr_arb.sv
// Scoreboard bench for cram_wr_arb: directed stimulus pushes expected CRAM writes, a negedge monitor pops and compares.
module tb_cram_wr_arb;
  import video_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cram_wr_arb_if #(.FIFO_DEPTH(4)) bus();
  cram_wr_arb #(.FIFO_DEPTH(4), .DMA_BURST(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  cram_wr_t cpu_q[$];
  cram_wr_t dma_q[$];
  bit       src_log[$];
  int       acks = 0;
  int       writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: DMA beats use addresses >= 0x80, CPU writes below, so each write maps to one queue.
  initial begin
    cram_wr_t got;
    cram_wr_t exp;
    forever begin
      @(negedge clk);
      if (bus.dma_ack === 1'b1) acks++;
      if (bus.cram_we === 1'b1) begin
        got = {bus.cram_addr, bus.cram_data};
        writes++;
        src_log.push_back(got.addr[7]);
        if (got.addr[7] ? (dma_q.size() == 0) : (cpu_q.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", got.addr, got.data);
        end else begin
          exp = got.addr[7] ? dma_q.pop_front() : cpu_q.pop_front();
          check(got.addr[7] ? "dma_write" : "cpu_write", got, exp);
        end
      end
    end
  end

  task automatic cpu_push(input logic [7:0] a, input logic [14:0] d, input bit expect_issue);
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_data = d;
    if (expect_issue) cpu_q.push_back({a, d});
  endtask

  task automatic dma_set(input logic [7:0] a, input logic [14:0] d, input bit expect_issue);
    bus.dma_req  = 1'b1;
    bus.dma_addr = a;
    bus.dma_data = d;
    if (expect_issue) dma_q.push_back({a, d});
  endtask

  task automatic dma_beats(input int n, input int base);
    bit acked;
    int t;
    for (int k = 0; k < n; k++) begin
      dma_set(8'h80 + 8'(k), 15'(base + k), 1'b1);
      t = 0;
      do begin
        @(negedge clk);
        acked = bus.dma_ack;
        step();
        t++;
      end while (!acked && t < 100);
      if (!acked) begin
        check("dma_ack_timeout", 0, 1);
        break;
      end
    end
    bus.dma_req = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((cpu_q.size() != 0 || dma_q.size() != 0 || bus.fifo_cnt != 0) && t < 200) begin
      step();
      t++;
    end
    step();
    check("drain_pending", cpu_q.size() + dma_q.size(), 0);
  endtask

  initial begin
    int a0;
    int w0;
    int bad;
    bit exp_seq[$];
    logic [2:0] seq3;

    rst = 1'b1;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.dma_req = 1'b0; bus.dma_addr = '0; bus.dma_data = '0;
    bus.blank = 1'b1; bus.ovf_clr = 1'b0;
    repeat (3) step();
    check("rst_cram_we", bus.cram_we, 0);
    check("rst_fifo_cnt", bus.fifo_cnt, 0);
    check("rst_cpu_ovf", bus.cpu_ovf, 0);
    check("rst_dma_ack", bus.dma_ack, 0);
    check("rst_state", bus.state, ARB_IDLE);
    rst = 1'b0;
    step();

    // Single CPU write: enqueue, grant, register.
    cpu_push(8'h1F, 15'h7C00, 1'b1);
    step();
    bus.cpu_we = 1'b0;
    check("single_cnt_after_push", bus.fifo_cnt, 1);
    check("single_we_early", bus.cram_we, 0);
    step();
    check("single_we_2cyc", bus.cram_we, 1);
    check("single_cnt_after_pop", bus.fifo_cnt, 0);
    check("single_addr", bus.cram_addr, 8'h1F);
    step();
    check("single_we_one_cycle", bus.cram_we, 0);
    check("single_addr_hold", bus.cram_addr, 8'h1F);

    // Overflow: DMA holds the port, writes 5 and 6 are dropped.
    a0 = acks;
    fork
      dma_beats(12, 'h100);
      begin
        for (int i = 0; i < 6; i++) begin
          cpu_push(8'h20 + 8'(i), 15'h1000 + 15'(i), i < 4);
          step();
        end
        bus.cpu_we = 1'b0;
        check("ovf_set", bus.cpu_ovf, 1);
        check("ovf_cnt_full", bus.fifo_cnt, 4);
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", bus.cpu_ovf, 0);
      end
    join
    wait_drain();
    check("ovf_dma_acks", acks - a0, 12);

    // Fairness: the first beat lands while the FIFO is still empty and does not count toward the burst.
    src_log.delete();
    a0 = acks;
    fork
      dma_beats(20, 'h200);
      begin
        cpu_push(8'h30, 15'h0030, 1'b1);
        step();
        cpu_push(8'h31, 15'h0031, 1'b1);
        step();
        bus.cpu_we = 1'b0;
      end
    join
    wait_drain();
    for (int i = 0; i < 9; i++) exp_seq.push_back(1'b1);
    exp_seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_seq.push_back(1'b1);
    exp_seq.push_back(1'b0);
    for (int i = 0; i < 3; i++) exp_seq.push_back(1'b1);
    check("fair_len", src_log.size(), 22);
    bad = 0;
    for (int i = 0; i < exp_seq.size() && i < src_log.size(); i++)
      if (src_log[i] != exp_seq[i]) bad++;
    check("fair_seq_mismatches", bad, 0);
    check("fair_dma_acks", acks - a0, 20);

    // Fill the FIFO behind four DMA beats, then push into the cycle that pops it.
    a0 = acks;
    for (int k = 0; k < 4; k++) begin
      dma_set(8'h80 + 8'(k), 15'h300 + 15'(k), 1'b1);
      cpu_push(8'h40 + 8'(k), 15'h400 + 15'(k), 1'b1);
      step();
    end
    bus.dma_req = 1'b0;
    check("full_cnt", bus.fifo_cnt, 4);
    cpu_push(8'h44, 15'h0404, 1'b1);
    step();
    bus.cpu_we = 1'b0;
    check("full_pop_push_cnt", bus.fifo_cnt, 4);
    check("full_pop_push_ovf", bus.cpu_ovf, 0);
    wait_drain();
    check("full_dma_acks", acks - a0, 4);

    // Reset with three CPU writes queued and DMA mid-burst: queued writes are lost.
    for (int k = 0; k < 3; k++) begin
      dma_set(8'h80 + 8'(k), 15'h500 + 15'(k), 1'b1);
      cpu_push(8'h50 + 8'(k), 15'h0550, 1'b0);
      step();
    end
    bus.cpu_we = 1'b0;
    check("midrst_cnt", bus.fifo_cnt, 3);
    rst = 1'b1;
    dma_set(8'h83, 15'h0503, 1'b0);
    @(negedge clk);
    check("midrst_ack_in_rst", bus.dma_ack, 0);
    step();
    w0 = writes;
    check("midrst_cram_we", bus.cram_we, 0);
    check("midrst_fifo_cnt", bus.fifo_cnt, 0);
    check("midrst_dma_ack", bus.dma_ack, 0);
    rst = 1'b0;
    bus.dma_req = 1'b0;
    repeat (10) step();
    check("midrst_no_stale", writes - w0, 0);

`ifdef CRAM_BLANK_WR_EN
    // Outside blanking both sources wait and CPU writes keep queuing.
    bus.blank = 1'b0;
    w0 = writes;
    dma_set(8'h90, 15'h0600, 1'b1);
    cpu_push(8'h60, 15'h0060, 1'b1);
    step();
    cpu_push(8'h61, 15'h0061, 1'b1);
    step();
    bus.cpu_we = 1'b0;
    repeat (4) step();
    check("blank_no_write", writes - w0, 0);
    check("blank_cnt", bus.fifo_cnt, 2);
    check("blank_dma_held", bus.dma_ack, 0);
    src_log.delete();
    bus.blank = 1'b1;
    @(negedge clk);
    check("blank_dma_ack", bus.dma_ack, 1);
    step();
    bus.dma_req = 1'b0;
    wait_drain();
    check("blank_len", src_log.size(), 3);
    seq3 = 3'b111;
    if (src_log.size() == 3) seq3 = {src_log[0], src_log[1], src_log[2]};
    check("blank_seq", seq3, 3'b100);
`else
    // Without the blanking option, blank=0 must not hold back a write.
    bus.blank = 1'b0;
    cpu_push(8'h70, 15'h0155, 1'b1);
    step();
    bus.cpu_we = 1'b0;
    step();
    check("blank_ignored", bus.cram_we, 1);
    wait_drain();
    bus.blank = 1'b1;
`endif

    check("final_cpu_q", cpu_q.size(), 0);
    check("final_dma_q", dma_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
